// File: rtl/tag_array_scanner.sv
// Port-B sweeper for the cache tag array: reads every entry in order and streams it,
// with its index, over a valid/ready channel while port A stays free for the core.
module tag_array_scanner #(
    parameter int ID           = 0,
    parameter int data_width   = 28,
    parameter int data_depth   = 16,
    parameter int valid_bit    = 27,
    parameter int skip_invalid = 0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(data_depth)-1:0]     read_addr_b,
    input  logic [data_width-1:0]             read_data_b,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(data_depth)-1:0]     out_index,
    output logic [data_width-1:0]             out_data,
    output logic                              out_last,
    output logic [$clog2(data_depth+1)-1:0]   emit_count
);

    localparam int AW = $clog2(data_depth);
    localparam int CW = $clog2(data_depth + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(data_depth - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_SEND    = 3'd3,
        S_ADVANCE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                state_r, state_nxt;
    logic                  busy_r, busy_nxt;
    logic                  done_r, done_nxt;
    logic [AW-1:0]         addr_r, addr_nxt;
    logic                  valid_r, valid_nxt;
    logic                  last_r, last_nxt;
    logic [AW-1:0]         index_r, index_nxt;
    logic [data_width-1:0] data_r, data_nxt;
    logic [CW-1:0]         count_r, count_nxt;
    logic                  entry_filtered_s;

    // An entry is dropped only when filtering is enabled and its valid flag is clear
    assign entry_filtered_s = (skip_invalid != 0) && !read_data_b[valid_bit];

    // Next-state and next-output logic for the sweep sequencer
    always_comb begin
        state_nxt = state_r;
        busy_nxt  = busy_r;
        done_nxt  = 1'b0;
        addr_nxt  = addr_r;
        valid_nxt = valid_r;
        last_nxt  = last_r;
        index_nxt = index_r;
        data_nxt  = data_r;
        count_nxt = count_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_READ;
                    addr_nxt  = '0;
                    count_nxt = '0;
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_READ: begin
                state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                data_nxt  = read_data_b;
                index_nxt = addr_r;
                if (entry_filtered_s) begin
                    state_nxt = S_ADVANCE;
                end else begin
                    state_nxt = S_SEND;
                    valid_nxt = 1'b1;
                    last_nxt  = (addr_r == LAST_ADDR);
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                    count_nxt = count_r + CW'(1);
                    state_nxt = S_ADVANCE;
                end else begin
                    state_nxt = S_SEND;
                end
            end
            S_ADVANCE: begin
                // Explicit end-of-array compare so non-power-of-two depths never wrap
                if (addr_r == LAST_ADDR) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    addr_nxt  = addr_r + AW'(1);
                    state_nxt = S_READ;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            addr_r  <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            index_r <= '0;
            data_r  <= '0;
            count_r <= '0;
        end else begin
            state_r <= state_nxt;
            busy_r  <= busy_nxt;
            done_r  <= done_nxt;
            addr_r  <= addr_nxt;
            valid_r <= valid_nxt;
            last_r  <= last_nxt;
            index_r <= index_nxt;
            data_r  <= data_nxt;
            count_r <= count_nxt;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign read_addr_b = addr_r;
    assign out_valid   = valid_r;
    assign out_last    = last_r;
    assign out_index   = index_r;
    assign out_data    = data_r;
    assign emit_count  = count_r;

`ifndef SYNTHESIS
    // Simulation trace of every emitted entry, tagged with the controller ID
    always_ff @(posedge clock) begin
        if (!reset && valid_r && out_ready) begin
            $display("tag_array_scanner %0d: emit index %0d data %h", ID, index_r, data_r);
        end else begin
        end
    end
`endif

endmodule

// File: tb/tb_tag_array_scanner.sv
// Self-checking bench for tag_array_scanner: three instances (plain, valid-filtering,
// depth 5) against a list-based model of which entries a sweep must emit.
module tb_tag_array_scanner;

    logic clock, reset, start, out_ready;
    int   sel;
    logic [27:0] mem [16];

    logic        busy0, done0, valid0, last0;
    logic [3:0]  addr0, index0;
    logic [4:0]  count0;
    logic [27:0] rdata0, data0;
    logic        busy1, done1, valid1, last1;
    logic [3:0]  addr1, index1;
    logic [4:0]  count1;
    logic [27:0] rdata1, data1;
    logic        busy2, done2, valid2, last2;
    logic [2:0]  addr2, index2;
    logic [2:0]  count2;
    logic [27:0] rdata2, data2;
    logic        start0, start1, start2;

    logic        m_busy, m_done, m_valid, m_last;
    int          m_addr, m_index, m_count;
    logic [27:0] m_data;

    int errors = 0;
    int checks = 0;

    int          beat_idx[$];
    logic [27:0] beat_data[$];
    bit          beat_last[$];
    int done_cnt, stab_err, max_addr, first_lat, first_hs, last_hs, done_n, count_at_done;
    bit busy_first, busy_after, timeout;

    assign start0 = start && (sel == 0);
    assign start1 = start && (sel == 1);
    assign start2 = start && (sel == 2);

    tag_array_scanner #(.ID(0)) dut0 (
        .clock(clock), .reset(reset), .start(start0), .busy(busy0), .done(done0),
        .read_addr_b(addr0), .read_data_b(rdata0), .out_valid(valid0), .out_ready(out_ready),
        .out_index(index0), .out_data(data0), .out_last(last0), .emit_count(count0));
    tag_array_scanner #(.ID(1), .skip_invalid(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .read_addr_b(addr1), .read_data_b(rdata1), .out_valid(valid1), .out_ready(out_ready),
        .out_index(index1), .out_data(data1), .out_last(last1), .emit_count(count1));
    tag_array_scanner #(.ID(2), .data_depth(5)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .read_addr_b(addr2), .read_data_b(rdata2), .out_valid(valid2), .out_ready(out_ready),
        .out_index(index2), .out_data(data2), .out_last(last2), .emit_count(count2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Registered port-B read of the shared tag store
    always @(posedge clock) begin
        rdata0 <= mem[addr0];
        rdata1 <= mem[addr1];
        rdata2 <= mem[{1'b0, addr2}];
    end

    // Route the selected instance onto the observation signals
    always_comb begin
        case (sel)
            0: begin
                m_busy = busy0; m_done = done0; m_valid = valid0; m_last = last0;
                m_addr = int'(addr0); m_index = int'(index0); m_count = int'(count0); m_data = data0;
            end
            1: begin
                m_busy = busy1; m_done = done1; m_valid = valid1; m_last = last1;
                m_addr = int'(addr1); m_index = int'(index1); m_count = int'(count1); m_data = data1;
            end
            default: begin
                m_busy = busy2; m_done = done2; m_valid = valid2; m_last = last2;
                m_addr = int'(addr2); m_index = int'(index2); m_count = int'(count2); m_data = data2;
            end
        endcase
    end

    // Reference: the ordered list of entries a sweep must emit, compared to observed beats
    function automatic int model_diffs(input int depth, input bit skip);
        int exp_idx[$];
        int d = 0;
        for (int i = 0; i < depth; i++)
            if (!skip || mem[i][27]) exp_idx.push_back(i);
        if (exp_idx.size() != beat_idx.size()) d++;
        for (int k = 0; k < exp_idx.size() && k < beat_idx.size(); k++)
            if (beat_idx[k] != exp_idx[k] || beat_data[k] !== mem[exp_idx[k]] ||
                beat_last[k] != (exp_idx[k] == depth - 1)) d++;
        return d;
    endfunction

    // Pulse start on the selected instance and record everything the sweep does
    task automatic collect(input int pct, input bit repulse, input int budget);
        bit pend = 1'b0;
        bit seen_done = 1'b0;
        int extra = 0;
        int p_idx = 0;
        logic [27:0] p_data = '0;
        beat_idx.delete(); beat_data.delete(); beat_last.delete();
        done_cnt = 0; stab_err = 0; max_addr = 0; first_lat = -1; first_hs = -1; last_hs = -1;
        done_n = -1; count_at_done = -1; busy_first = 1'b0; busy_after = 1'b1; timeout = 1'b0;
        @(negedge clock);
        start = 1'b1;
        out_ready = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clock);
            start = 1'b0;
            if (n == 1) busy_first = m_busy;
            if (m_addr > max_addr) max_addr = m_addr;
            if (pend && (!m_valid || m_index != p_idx || m_data !== p_data)) stab_err++;
            if (m_valid && first_lat < 0) first_lat = n;
            if (seen_done && n == done_n + 1) busy_after = m_busy;
            if (m_done) begin
                done_cnt++;
                if (!seen_done) begin
                    seen_done = 1'b1; done_n = n; count_at_done = m_count;
                end
                if (repulse) start = 1'b1;
            end
            if (repulse && n == 5) start = 1'b1;
            out_ready = ($urandom_range(99) < pct);
            if (m_valid && out_ready) begin
                beat_idx.push_back(m_index); beat_data.push_back(m_data); beat_last.push_back(m_last);
                if (first_hs < 0) first_hs = n;
                last_hs = n;
            end
            pend = m_valid && !out_ready; p_idx = m_index; p_data = m_data;
            if (seen_done) begin
                extra++;
                if (extra > 8) break;
            end
        end
        if (!seen_done) timeout = 1'b1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; sel = 0;
        repeat (3) @(negedge clock);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if ({m_busy, m_done, m_valid, m_last} !== 4'b0000 || m_addr != 0 || m_index != 0 ||
                m_data !== 28'd0 || m_count != 0) begin
                errors++;
                $display("FAIL reset_values[%0d]: got busy=%0d done=%0d valid=%0d last=%0d addr=%0d idx=%0d data=%0h cnt=%0d, expected all 0",
                         s, m_busy, m_done, m_valid, m_last, m_addr, m_index, m_data, m_count);
            end
        end
        reset = 1'b0;
        sel = 0;
        @(negedge clock);
    endtask

    task automatic test_full_sweep();
        int d;
        sel = 0;
        for (int i = 0; i < 16; i++) mem[i] = {1'b1, 27'(i * 3)};
        collect(100, 1'b0, 300);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL full_timeout: got no done within budget, expected done"); end
        d = model_diffs(16, 1'b0);
        checks++; if (d !== 0) begin errors++; $display("FAIL full_beats: got %0d bad beats of %0d, expected 0 of 16", d, beat_idx.size()); end
        checks++; if (busy_first !== 1'b1) begin errors++; $display("FAIL full_busy: got %0d, expected 1", busy_first); end
        checks++; if (first_lat !== 3) begin errors++; $display("FAIL full_latency: got %0d, expected 3", first_lat); end
        checks++; if (last_hs - first_hs !== 60) begin errors++; $display("FAIL full_throughput: got %0d cycles, expected 60", last_hs - first_hs); end
        checks++; if (done_n !== last_hs + 2) begin errors++; $display("FAIL full_done_time: got %0d, expected %0d", done_n, last_hs + 2); end
        checks++; if (count_at_done !== 16) begin errors++; $display("FAIL full_emit_count: got %0d, expected 16", count_at_done); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL full_done_count: got %0d, expected 1", done_cnt); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL full_busy_after: got %0d, expected 0", busy_after); end
    endtask

    task automatic test_skip_invalid();
        int d;
        sel = 1;
        for (int i = 0; i < 16; i++) mem[i] = {(i == 2 || i == 5 || i == 15) ? 1'b1 : 1'b0, 27'($urandom)};
        collect(100, 1'b0, 300);
        d = model_diffs(16, 1'b1);
        checks++; if (timeout !== 1'b0 || d !== 0) begin errors++; $display("FAIL skip_beats: got %0d bad beats (timeout=%0d), expected 0", d, timeout); end
        checks++; if (count_at_done !== 3) begin errors++; $display("FAIL skip_emit_count: got %0d, expected 3", count_at_done); end
        checks++; if (first_lat !== 9) begin errors++; $display("FAIL skip_latency: got %0d, expected 9", first_lat); end
        mem[15][27] = 1'b0;
        collect(100, 1'b0, 300);
        d = model_diffs(16, 1'b1);
        checks++; if (d !== 0) begin errors++; $display("FAIL skip_nolast_beats: got %0d bad beats, expected 0", d); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL skip_nolast_done: got %0d, expected 1", done_cnt); end
        checks++; if (count_at_done !== 2) begin errors++; $display("FAIL skip_nolast_count: got %0d, expected 2", count_at_done); end
    endtask

    task automatic test_random_ready();
        int d;
        sel = 0;
        for (int i = 0; i < 16; i++) mem[i] = 28'($urandom);
        collect(30, 1'b0, 2000);
        d = model_diffs(16, 1'b0);
        checks++; if (timeout !== 1'b0 || d !== 0) begin errors++; $display("FAIL rand_beats: got %0d bad beats (timeout=%0d), expected 0", d, timeout); end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL rand_stability: got %0d unstable cycles, expected 0", stab_err); end
        checks++; if (count_at_done !== 16) begin errors++; $display("FAIL rand_emit_count: got %0d, expected 16", count_at_done); end
    endtask

    task automatic test_reset_mid_sweep();
        int d;
        int bad = 0;
        bit found = 1'b0;
        sel = 0;
        for (int i = 0; i < 16; i++) mem[i] = 28'($urandom);
        @(negedge clock);
        start = 1'b1; out_ready = 1'b1;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clock);
            start = 1'b0;
            if (m_valid && m_index == 7) begin out_ready = 1'b0; found = 1'b1; end
            else out_ready = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL rst_reach_idx7: got not reached, expected index 7 in SEND"); end
        @(negedge clock);
        checks++; if (m_valid !== 1'b1 || m_index != 7 || m_data !== mem[7]) begin errors++; $display("FAIL rst_hold: got valid=%0d idx=%0d, expected valid=1 idx=7", m_valid, m_index); end
        reset = 1'b1; start = 1'b1;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        checks++;
        if ({m_busy, m_done, m_valid, m_last} !== 4'b0000 || m_addr != 0 || m_index != 0 ||
            m_data !== 28'd0 || m_count != 0) begin
            errors++;
            $display("FAIL rst_mid_values: got busy=%0d done=%0d valid=%0d idx=%0d cnt=%0d, expected all 0",
                     m_busy, m_done, m_valid, m_index, m_count);
        end
        repeat (6) begin
            @(negedge clock);
            if (m_done || m_busy || m_valid) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rst_stays_idle: got %0d active cycles, expected 0", bad); end
        collect(100, 1'b0, 300);
        d = model_diffs(16, 1'b0);
        checks++; if (timeout !== 1'b0 || d !== 0) begin errors++; $display("FAIL rst_restart: got %0d bad beats (timeout=%0d), expected 0", d, timeout); end
    endtask

    task automatic test_back_to_back();
        int d;
        sel = 0;
        for (int i = 0; i < 16; i++) mem[i] = 28'($urandom);
        collect(100, 1'b1, 300);
        d = model_diffs(16, 1'b0);
        checks++; if (timeout !== 1'b0 || d !== 0) begin errors++; $display("FAIL repulse_beats: got %0d bad beats (%0d beats), expected 0", d, beat_idx.size()); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL repulse_done_count: got %0d, expected 1", done_cnt); end
    endtask

    task automatic test_depth5();
        int d;
        sel = 2;
        for (int i = 0; i < 16; i++) mem[i] = 28'($urandom);
        collect(60, 1'b0, 500);
        d = model_diffs(5, 1'b0);
        checks++; if (timeout !== 1'b0 || d !== 0) begin errors++; $display("FAIL d5_beats: got %0d bad beats (timeout=%0d), expected 0", d, timeout); end
        checks++; if (max_addr > 4) begin errors++; $display("FAIL d5_max_addr: got %0d, expected <= 4", max_addr); end
        checks++; if (count_at_done !== 5) begin errors++; $display("FAIL d5_emit_count: got %0d, expected 5", count_at_done); end
        checks++; if (done_n !== last_hs + 2) begin errors++; $display("FAIL d5_done_time: got %0d, expected %0d", done_n, last_hs + 2); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_full_sweep();
        test_skip_invalid();
        test_random_ready();
        test_reset_mid_sweep();
        test_back_to_back();
        test_depth5();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
